cntr_ctrl: RTL
==============

CNTR_CTRL -- requirements
Module: cntr_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the register window.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-005 SHALL have ports wbs_adr_i and wbs_dat_i  input  32 each  Wishbone address and write data; wbs_sel_i  input  4  byte enables.
REQ-006 SHALL have ports wbs_dat_o  output  32  read data; wbs_ack_o  output  1  transfer acknowledge.
REQ-007 SHALL have port cnt_val_i  input  32  current value of the external counter datapath.
REQ-008 SHALL have ports cnt_en_o  output  1  count enable; cnt_load_o  output  1  load strobe; cnt_load_val_o  output  32  load value.
REQ-009 SHALL have ports io_oeb_o  output  38  pad output-enable bar, 1 = input; user_irq_o  output  3  interrupts.

Function
REQ-010 SHALL decode offsets: 0x00 CTRL, 0x04 LOAD, 0x08 CMP, 0x0C STATUS, 0x10 OEB_LO (bits 31:0), 0x14 OEB_HI (bits 5:0).
REQ-011 SHALL define CTRL as: bit0 START, self-clearing, reads 0; bit1 STOP, self-clearing, reads 0; bit2 ONESHOT; bit3 IRQ_EN.
REQ-012 SHALL define STATUS as: bits1:0 FSM state; bit2 MATCH, sticky, write-1-to-clear; remaining bits read 0.
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, one cycle after cyc&stb is seen with ack low; ack never asserts on consecutive cycles.
REQ-014 SHALL honour wbs_sel_i per byte for LOAD, CMP, OEB_LO and OEB_HI; CTRL and STATUS writes use byte 0 only.
REQ-015 SHALL ack addresses outside BASE_ADDR..BASE_ADDR+0x14 and unused offsets, return 0 on reads, and ignore writes.
REQ-016 SHALL present wbs_dat_o valid in the ack cycle and hold it at 0 otherwise.
REQ-017 SHALL implement FSM states IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-018 SHALL move IDLE or DONE to LOAD on a START write; START in LOAD or RUN is ignored.
REQ-019 SHALL, in LOAD, drive cnt_load_o=1 and cnt_load_val_o=LOAD for exactly one cycle, then enter RUN.
REQ-020 SHALL drive cnt_en_o=1 only in RUN.
REQ-021 SHALL, in RUN, compare cnt_val_i==CMP combinationally each cycle; on equality set MATCH, then go to DONE if ONESHOT=1, else go to LOAD (periodic reload).
REQ-022 SHALL, on a STOP write, go to IDLE from any state on the next cycle; if STOP and START are written together, STOP wins.
REQ-023 SHALL still set MATCH when a match and a STOP occur in the same cycle, with the state going to IDLE.
REQ-024 SHALL, when a MATCH W1C coincides with a new match, leave MATCH set (set wins).
REQ-025 SHALL drive user_irq_o[0]=MATCH&IRQ_EN, registered; user_irq_o[2:1]=0.
REQ-026 SHALL drive io_oeb_o={OEB_HI[5:0],OEB_LO} directly from the registers.
REQ-027 SHALL keep cnt_load_val_o equal to the LOAD register at all times; only cnt_load_o qualifies it.

Reset
REQ-028 SHALL, on wb_rst_ni=0 at a clock edge, set FSM=IDLE, CTRL=0, LOAD=0, CMP=0xFFFF_FFFF, MATCH=0, OEB=all ones (38'h3F_FFFF_FFFF).
REQ-029 SHALL hold wbs_ack_o=0, wbs_dat_o=0, cnt_en_o=0, cnt_load_o=0 and user_irq_o=0 during and after reset.
REQ-030 SHALL drop cnt_en_o on the edge that samples reset when reset occurs mid-RUN, and SHALL drop any in-flight ack.

Structure
REQ-031 SHALL place the state enum, register offsets and CTRL/STATUS bit positions in shared package cntr_ctrl_pkg.
REQ-032 SHALL split Wishbone decode and the register file into sub-module cntr_ctrl_regs; the FSM and compare logic stay in cntr_ctrl.

Verification
REQ-033 SHALL cover: reset, then read STATUS -> 0x0; read OEB_LO -> 0xFFFF_FFFF; io_oeb_o all ones.
REQ-034 SHALL cover: write LOAD=5, CMP=8, CTRL=0x5 (START, ONESHOT) -> one cnt_load_o pulse with val 5; cnt_en_o high; with cnt_val_i=8 -> DONE, MATCH=1, cnt_en_o=0.
REQ-035 SHALL cover: periodic mode (CTRL=0x9), CMP=3 -> each match gives LOAD (one cycle, cnt_en_o=0) then RUN; user_irq_o[0]=1 one cycle after the first match.
REQ-036 SHALL cover: STOP written in the same cycle as cnt_val_i==CMP -> state IDLE, MATCH=1; then STATUS write 0x4 -> MATCH=0 and irq low.
REQ-037 SHALL cover: write 0xAABBCCDD to LOAD with sel=4'b0101 after reset -> LOAD reads 0x00BB00DD.
REQ-038 SHALL cover: read of BASE_ADDR+0x40 -> acked once with data 0; wb_rst_ni pulled low mid-RUN -> cnt_en_o=0 on the next edge.

Source files
------------

// File: rtl/cntr_ctrl_pkg.sv
// Shared definitions for the counter controller: FSM states, register map,
// CTRL/STATUS bit positions and a byte-lane merge helper.
package cntr_ctrl_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SEL_W    = DATA_W / 8;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned OEB_W    = 38;
  localparam int unsigned OEB_HI_W = OEB_W - DATA_W;
  localparam int unsigned IRQ_W    = 3;

  // Highest byte offset inside the register window
  localparam logic [DATA_W-1:0] WIN_SPAN = 32'h0000_0014;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 5'h00;
  localparam logic [OFF_W-1:0] OFF_LOAD   = 5'h04;
  localparam logic [OFF_W-1:0] OFF_CMP    = 5'h08;
  localparam logic [OFF_W-1:0] OFF_STATUS = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_OEB_LO = 5'h10;
  localparam logic [OFF_W-1:0] OFF_OEB_HI = 5'h14;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_STOP    = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_MATCH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Persistent CTRL bits (START/STOP are strobes and are not stored)
  typedef struct packed {
    logic irq_en;
    logic oneshot;
  } ctrl_t;

  // Replace the byte lanes of cur selected by sel with those of wr
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] wr,
                                                    input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = wr[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cntr_ctrl_if.sv
// Wishbone classic slave bus bundle for the counter controller.
// Signals: cyc/stb/we/adr/dat_i/sel from the master, dat_o/ack from the slave.
interface cntr_ctrl_if;
  import cntr_ctrl_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [DATA_W-1:0] wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic [SEL_W-1:0]  wbs_sel_i;
  logic [DATA_W-1:0] wbs_dat_o;
  logic              wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/cntr_ctrl_regs.sv
// Wishbone decode and register file for the counter controller.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   wb           - Wishbone slave bus
//   state        - current FSM state (read back through STATUS)
//   match_set_c  - compare hit this cycle, sets sticky MATCH
//   start_c/stop_c - CTRL START/STOP write strobes (combinational)
//   ctrl         - ONESHOT / IRQ_EN
//   load_val, cmp_val, oeb - LOAD, CMP and pad output-enable registers
//   irq          - registered MATCH & IRQ_EN
module cntr_ctrl_regs
  import cntr_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  cntr_ctrl_if.slave        wb,
  input  state_e            state,
  input  logic              match_set_c,
  output logic              start_c,
  output logic              stop_c,
  output ctrl_t             ctrl,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] cmp_val,
  output logic [OEB_W-1:0]  oeb,
  output logic              irq
);

  logic                ack_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   load_q, load_d;
  logic [DATA_W-1:0]   cmp_q, cmp_d;
  logic [DATA_W-1:0]   oeb_lo_q, oeb_lo_d;
  logic [OEB_HI_W-1:0] oeb_hi_q, oeb_hi_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                match_q, match_d;
  logic                irq_q;

  logic                req_c, in_win_c, wr_c, rd_c;
  logic [DATA_W-1:0]   off_c, rdata_c;
  logic [OFF_W-1:0]    reg_off_c;

  // A new request is one seen while ack is low, so ack can never repeat
  assign req_c     = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
  assign off_c     = wb.wbs_adr_i - BASE_ADDR;
  assign in_win_c  = (off_c <= WIN_SPAN);
  assign reg_off_c = off_c[OFF_W-1:0];
  assign wr_c      = req_c & in_win_c & wb.wbs_we_i;
  assign rd_c      = req_c & ~wb.wbs_we_i;

  // Read mux; anything outside the window or on an unused offset reads 0
  always_comb begin
    rdata_c = '0;
    if (in_win_c) begin
      case (reg_off_c)
        OFF_CTRL: begin
          rdata_c[CTRL_ONESHOT] = ctrl_q.oneshot;
          rdata_c[CTRL_IRQ_EN]  = ctrl_q.irq_en;
        end
        OFF_LOAD:   rdata_c = load_q;
        OFF_CMP:    rdata_c = cmp_q;
        OFF_STATUS: begin
          rdata_c[STAT_STATE_LSB +: 2] = state;
          rdata_c[STAT_MATCH]          = match_q;
        end
        OFF_OEB_LO: rdata_c = oeb_lo_q;
        OFF_OEB_HI: rdata_c[OEB_HI_W-1:0] = oeb_hi_q;
        default:    rdata_c = '0;
      endcase
    end
  end

  // Register write decode and START/STOP strobes
  always_comb begin
    load_d   = load_q;
    cmp_d    = cmp_q;
    oeb_lo_d = oeb_lo_q;
    oeb_hi_d = oeb_hi_q;
    ctrl_d   = ctrl_q;
    match_d  = match_q;
    start_c  = 1'b0;
    stop_c   = 1'b0;
    if (wr_c) begin
      case (reg_off_c)
        OFF_CTRL: begin
          if (wb.wbs_sel_i[0]) begin
            ctrl_d.oneshot = wb.wbs_dat_i[CTRL_ONESHOT];
            ctrl_d.irq_en  = wb.wbs_dat_i[CTRL_IRQ_EN];
            start_c        = wb.wbs_dat_i[CTRL_START];
            stop_c         = wb.wbs_dat_i[CTRL_STOP];
          end
        end
        OFF_LOAD:   load_d   = merge_bytes(load_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OFF_CMP:    cmp_d    = merge_bytes(cmp_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OFF_STATUS: begin
          if (wb.wbs_sel_i[0] && wb.wbs_dat_i[STAT_MATCH]) match_d = 1'b0;
        end
        OFF_OEB_LO: oeb_lo_d = merge_bytes(oeb_lo_q, wb.wbs_dat_i, wb.wbs_sel_i);
        OFF_OEB_HI: begin
          if (wb.wbs_sel_i[0]) oeb_hi_d = wb.wbs_dat_i[OEB_HI_W-1:0];
        end
        default: ;
      endcase
    end
    // A new match overrides a simultaneous W1C
    if (match_set_c) match_d = 1'b1;
  end

  // Register state and bus response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      load_q   <= '0;
      cmp_q    <= '1;
      oeb_lo_q <= '1;
      oeb_hi_q <= '1;
      ctrl_q   <= '0;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= req_c;
      dat_q    <= rd_c ? rdata_c : '0;
      load_q   <= load_d;
      cmp_q    <= cmp_d;
      oeb_lo_q <= oeb_lo_d;
      oeb_hi_q <= oeb_hi_d;
      ctrl_q   <= ctrl_d;
      match_q  <= match_d;
      irq_q    <= match_d & ctrl_d.irq_en;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign ctrl         = ctrl_q;
  assign load_val     = load_q;
  assign cmp_val      = cmp_q;
  assign oeb          = {oeb_hi_q, oeb_lo_q};
  assign irq          = irq_q;

endmodule

// File: rtl/cntr_ctrl.sv
// Counter controller: Wishbone-programmed FSM that loads, enables and
// compares an external counter datapath.
// Ports:
//   wb_clk_i, wb_rst_ni - clock, synchronous active-low reset
//   wb                  - Wishbone slave bus
//   cnt_val_i           - current external counter value
//   cnt_en_o            - count enable (RUN only)
//   cnt_load_o          - one-cycle load strobe, cnt_load_val_o its value
//   io_oeb_o            - pad output-enable bar
//   user_irq_o          - bit 0 is MATCH & IRQ_EN, others tied low
module cntr_ctrl
  import cntr_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  cntr_ctrl_if.slave        wb,
  input  logic [DATA_W-1:0] cnt_val_i,
  output logic              cnt_en_o,
  output logic              cnt_load_o,
  output logic [DATA_W-1:0] cnt_load_val_o,
  output logic [OEB_W-1:0]  io_oeb_o,
  output logic [IRQ_W-1:0]  user_irq_o
);

  state_e            state_q, state_d;
  logic              start_c, stop_c, match_c;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] load_val, cmp_val;
  logic              irq;
  logic              en_q, load_q;

  cntr_ctrl_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .wb          (wb),
    .state       (state_q),
    .match_set_c (match_c),
    .start_c     (start_c),
    .stop_c      (stop_c),
    .ctrl        (ctrl),
    .load_val    (load_val),
    .cmp_val     (cmp_val),
    .oeb         (io_oeb_o),
    .irq         (irq)
  );

  assign match_c = (state_q == ST_RUN) && (cnt_val_i == cmp_val);

  // Next-state logic; STOP takes priority over everything
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_c) state_d = ST_LOAD;
        ST_LOAD:          state_d = ST_RUN;
        ST_RUN:           if (match_c) state_d = ctrl.oneshot ? ST_DONE : ST_LOAD;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // State register; enable and load strobe are registered from the next state
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == ST_RUN);
      load_q  <= (state_d == ST_LOAD);
    end
  end

  assign cnt_en_o       = en_q;
  assign cnt_load_o     = load_q;
  assign cnt_load_val_o = load_val;
  assign user_irq_o     = {{(IRQ_W-1){1'b0}}, irq};

endmodule
